// File: rtl/nibble_demux_assembler_if.sv
// Bus bundle for nibble_demux_assembler: beat input side, word output side,
// and the error/count/timeout status lines.
interface nibble_demux_assembler_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_sel;
    logic [WIDTH-1:0]     in_data;
    logic                 in_ready;
    logic                 flush;
    logic [2*WIDTH-1:0]   out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 seq_err;
    logic                 err_clr;
    logic [7:0]           pair_count;
    logic                 timeout;

    modport master (
        output in_valid, in_sel, in_data, flush, out_ready, err_clr,
        input  in_ready, out_data, out_valid, seq_err, pair_count, timeout
    );

    modport slave (
        input  in_valid, in_sel, in_data, flush, out_ready, err_clr,
        output in_ready, out_data, out_valid, seq_err, pair_count, timeout
    );
endinterface

// File: rtl/nibble_demux_assembler.sv
// Reassembles low/high beats from a 2:1 time-multiplexed bus into one word.
// Optional partial-word idle timeout is enabled by defining DEMUX_TIMEOUT_EN.
module nibble_demux_assembler #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    nibble_demux_assembler_if.slave      bus
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT must be in 1..255");
    end

    logic [1:0]           state_q, state_d;
    logic [WIDTH-1:0]     low_q, low_d;
    logic [2*WIDTH-1:0]   out_data_q, out_data_d;
    logic                 seq_err_q, seq_err_d;
    logic [7:0]           pair_count_q, pair_count_d;
    logic                 in_ready;
    logic                 beat;
    logic                 handoff;
    logic                 set_err;

`ifdef DEMUX_TIMEOUT_EN
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);
    logic [7:0]           idle_cnt_q, idle_cnt_d;
    logic                 timeout_q, timeout_d;
`endif

    // A held word blocks new beats unless the consumer frees it this cycle.
    assign in_ready = (state_q != ST_FULL) || bus.out_ready;
    assign beat     = bus.in_valid && in_ready;
    assign handoff  = (state_q == ST_FULL) && bus.out_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        low_d        = low_q;
        out_data_d   = out_data_q;
        pair_count_d = pair_count_q;
        set_err      = 1'b0;
`ifdef DEMUX_TIMEOUT_EN
        idle_cnt_d   = 8'd0;
        timeout_d    = 1'b0;
`endif

        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (beat) begin
                        if (!bus.in_sel) begin
                            low_d   = bus.in_data;
                            state_d = ST_HALF;
                        end else begin
                            set_err = 1'b1;
                        end
                    end
                end
                ST_HALF: begin
                    if (beat) begin
                        if (bus.in_sel) begin
                            out_data_d = {bus.in_data, low_q};
                            state_d    = ST_FULL;
                        end else begin
                            low_d   = bus.in_data;
                            set_err = 1'b1;
                        end
                    end else begin
`ifdef DEMUX_TIMEOUT_EN
                        if (idle_cnt_q == IDLE_LAST) begin
                            state_d   = ST_EMPTY;
                            low_d     = '0;
                            set_err   = 1'b1;
                            timeout_d = 1'b1;
                        end else begin
                            idle_cnt_d = idle_cnt_q + 8'd1;
                        end
`endif
                    end
                end
                ST_FULL: begin
                    if (handoff) begin
                        pair_count_d = pair_count_q + 8'd1;
                        state_d      = ST_EMPTY;
                        if (beat) begin
                            if (!bus.in_sel) begin
                                low_d   = bus.in_data;
                                state_d = ST_HALF;
                            end else begin
                                set_err = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // Setting wins over clearing so an error in the clear cycle is not lost.
        if (set_err) begin
            seq_err_d = 1'b1;
        end else if (bus.err_clr) begin
            seq_err_d = 1'b0;
        end else begin
            seq_err_d = seq_err_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            low_q        <= '0;
            out_data_q   <= '0;
            seq_err_q    <= 1'b0;
            pair_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            low_q        <= low_d;
            out_data_q   <= out_data_d;
            seq_err_q    <= seq_err_d;
            pair_count_q <= pair_count_d;
        end
    end

`ifdef DEMUX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.in_ready   = in_ready;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = (state_q == ST_FULL);
    assign bus.seq_err    = seq_err_q;
    assign bus.pair_count = pair_count_q;
endmodule

// File: tb/tb_nibble_demux_assembler.sv
// Directed self-checking bench for nibble_demux_assembler (TIMEOUT=3);
// the timeout scenario follows whichever build DEMUX_TIMEOUT_EN selects.
module tb_nibble_demux_assembler;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_compared = 0;
    int   n_mismatched = 0;

    nibble_demux_assembler_if #(.WIDTH(WIDTH)) bus ();

    nibble_demux_assembler #(.WIDTH(WIDTH), .TIMEOUT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic sel, input logic [3:0] d);
        bus.in_valid = v;
        bus.in_sel   = sel;
        bus.in_data  = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_compared++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00) begin
            n_mismatched++;
            $display("FAIL reset_out: valid=%b data=%h want 0/00", bus.out_valid, bus.out_data);
        end
        n_compared++;
        if (bus.seq_err !== 1'b0 || bus.pair_count !== 8'd0 || bus.timeout !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_status: err=%b cnt=%0d to=%b want 0/0/0", bus.seq_err, bus.pair_count, bus.timeout);
        end
        n_compared++;
        if (bus.in_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_basic_pair();
        bus.out_ready = 1'b1;
        drive(1, 0, 4'h5); step();
        drive(1, 1, 4'hA); step();
        drive(0, 0, 4'h0);
        n_compared++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.pair_count !== 8'd0) begin
            n_mismatched++;
            $display("FAIL basic_word: valid=%b data=%h cnt=%0d want 1/a5/0", bus.out_valid, bus.out_data, bus.pair_count);
        end
        step();
        n_compared++;
        if (bus.out_valid !== 1'b0 || bus.pair_count !== 8'd1) begin
            n_mismatched++;
            $display("FAIL basic_handoff: valid=%b cnt=%0d want 0/1", bus.out_valid, bus.pair_count);
        end
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        drive(1, 0, 4'h3); step();
        drive(1, 1, 4'hC); step();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 4'h9);
            #1;
            n_compared++;
            if (bus.in_ready !== 1'b0) begin
                n_mismatched++;
                $display("FAIL stall_in_ready[%0d]: got %b want 0", i, bus.in_ready);
            end
            step();
            n_compared++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hC3) begin
                n_mismatched++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%h want 1/c3", i, bus.out_valid, bus.out_data);
            end
        end
        bus.out_ready = 1'b1;
        drive(1, 0, 4'h7);
        #1;
        n_compared++;
        if (bus.in_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL stall_release_ready: got %b want 1", bus.in_ready);
        end
        step();
        n_compared++;
        if (bus.out_valid !== 1'b0 || bus.pair_count !== 8'd2) begin
            n_mismatched++;
            $display("FAIL stall_handoff: valid=%b cnt=%0d want 0/2", bus.out_valid, bus.pair_count);
        end
        drive(1, 1, 4'h8); step();
        drive(0, 0, 4'h0);
        n_compared++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h87 || bus.seq_err !== 1'b0) begin
            n_mismatched++;
            $display("FAIL stall_low_kept: valid=%b data=%h err=%b want 1/87/0", bus.out_valid, bus.out_data, bus.seq_err);
        end
        step();
    endtask

    task automatic test_seq_err();
        drive(1, 1, 4'hE); step();
        drive(0, 0, 4'h0);
        n_compared++;
        if (bus.seq_err !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL err_empty_high: err=%b valid=%b want 1/0", bus.seq_err, bus.out_valid);
        end
        bus.err_clr = 1'b1;
        drive(1, 1, 4'hD); step();
        drive(0, 0, 4'h0);
        n_compared++;
        if (bus.seq_err !== 1'b1) begin
            n_mismatched++;
            $display("FAIL err_set_beats_clr: got %b want 1", bus.seq_err);
        end
        step();
        bus.err_clr = 1'b0;
        n_compared++;
        if (bus.seq_err !== 1'b0) begin
            n_mismatched++;
            $display("FAIL err_clear: got %b want 0", bus.seq_err);
        end
        drive(1, 0, 4'h1); step();
        drive(1, 0, 4'h6); step();
        n_compared++;
        if (bus.seq_err !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL err_half_low: err=%b valid=%b want 1/0", bus.seq_err, bus.out_valid);
        end
        drive(1, 1, 4'h2); step();
        drive(0, 0, 4'h0);
        n_compared++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h26) begin
            n_mismatched++;
            $display("FAIL err_overwrite_word: valid=%b data=%h want 1/26", bus.out_valid, bus.out_data);
        end
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        n_compared++;
        if (bus.pair_count !== 8'd4 || bus.seq_err !== 1'b0) begin
            n_mismatched++;
            $display("FAIL err_tail: cnt=%0d err=%b want 4/0", bus.pair_count, bus.seq_err);
        end
    endtask

    task automatic test_flush();
        drive(1, 0, 4'h1); step();
        bus.flush = 1'b1;
        drive(1, 1, 4'hF); step();
        bus.flush = 1'b0;
        drive(0, 0, 4'h0);
        n_compared++;
        if (bus.out_valid !== 1'b0 || bus.seq_err !== 1'b0 || bus.pair_count !== 8'd4) begin
            n_mismatched++;
            $display("FAIL flush_drop: valid=%b err=%b cnt=%0d want 0/0/4", bus.out_valid, bus.seq_err, bus.pair_count);
        end
        drive(1, 0, 4'h2); step();
        drive(1, 1, 4'h4); step();
        drive(0, 0, 4'h0);
        n_compared++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h42 || bus.seq_err !== 1'b0) begin
            n_mismatched++;
            $display("FAIL flush_next_word: valid=%b data=%h err=%b want 1/42/0", bus.out_valid, bus.out_data, bus.seq_err);
        end
        step();
    endtask

    // Words are streamed back to back: each low beat also hands off the previous word.
    task automatic stream_words(input int n);
        logic [7:0] idx;
        for (int i = 0; i < n; i++) begin
            idx = 8'(i);
            drive(1, 0, idx[3:0]); step();
            drive(1, 1, idx[7:4]); step();
        end
        drive(0, 0, 4'h0);
    endtask

    task automatic test_back_to_back();
        stream_words(250);
        n_compared++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd249) begin
            n_mismatched++;
            $display("FAIL b2b_last_word: valid=%b data=%h want 1/f9", bus.out_valid, bus.out_data);
        end
        step();
        n_compared++;
        if (bus.pair_count !== 8'd255 || bus.seq_err !== 1'b0) begin
            n_mismatched++;
            $display("FAIL b2b_count_255: cnt=%0d err=%b want 255/0", bus.pair_count, bus.seq_err);
        end
        stream_words(1);
        step();
        n_compared++;
        if (bus.pair_count !== 8'd0) begin
            n_mismatched++;
            $display("FAIL b2b_wrap: cnt=%0d want 0", bus.pair_count);
        end
        stream_words(256);
        step();
        n_compared++;
        if (bus.pair_count !== 8'd0 || bus.out_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL b2b_256_wrap: cnt=%0d valid=%b want 0/0", bus.pair_count, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_word();
        stream_words(1);
        step();
        drive(1, 1, 4'hB); step();
        drive(1, 0, 4'h9); step();
        drive(0, 0, 4'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_compared++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.seq_err !== 1'b0 ||
            bus.pair_count !== 8'd0 || bus.timeout !== 1'b0) begin
            n_mismatched++;
            $display("FAIL midreset_outputs: valid=%b data=%h err=%b cnt=%0d to=%b want 0/00/0/0/0",
                     bus.out_valid, bus.out_data, bus.seq_err, bus.pair_count, bus.timeout);
        end
        drive(1, 1, 4'h3); step();
        drive(0, 0, 4'h0);
        n_compared++;
        if (bus.seq_err !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL midreset_low_lost: err=%b valid=%b want 1/0", bus.seq_err, bus.out_valid);
        end
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
    endtask

    task automatic test_timeout();
        drive(1, 0, 4'h5); step();
        drive(0, 0, 4'h0);
        step();
        step();
        n_compared++;
        if (bus.timeout !== 1'b0) begin
            n_mismatched++;
            $display("FAIL to_early: got %b want 0", bus.timeout);
        end
        step();
`ifdef DEMUX_TIMEOUT_EN
        n_compared++;
        if (bus.timeout !== 1'b1 || bus.seq_err !== 1'b1) begin
            n_mismatched++;
            $display("FAIL to_pulse: to=%b err=%b want 1/1", bus.timeout, bus.seq_err);
        end
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        n_compared++;
        if (bus.timeout !== 1'b0 || bus.seq_err !== 1'b0) begin
            n_mismatched++;
            $display("FAIL to_one_cycle: to=%b err=%b want 0/0", bus.timeout, bus.seq_err);
        end
        drive(1, 1, 4'hA); step();
        drive(0, 0, 4'h0);
        n_compared++;
        if (bus.seq_err !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL to_late_high: err=%b valid=%b want 1/0", bus.seq_err, bus.out_valid);
        end
`else
        n_compared++;
        if (bus.timeout !== 1'b0 || bus.seq_err !== 1'b0) begin
            n_mismatched++;
            $display("FAIL no_to_idle: to=%b err=%b want 0/0", bus.timeout, bus.seq_err);
        end
        step();
        drive(1, 1, 4'hA); step();
        drive(0, 0, 4'h0);
        n_compared++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.seq_err !== 1'b0) begin
            n_mismatched++;
            $display("FAIL no_to_late_high: valid=%b data=%h err=%b want 1/a5/0", bus.out_valid, bus.out_data, bus.seq_err);
        end
`endif
        step();
    endtask

    initial begin
        drive(0, 0, 4'h0);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus.err_clr   = 1'b0;
        test_reset();
        test_basic_pair();
        test_stall();
        test_seq_err();
        test_flush();
        test_back_to_back();
        test_reset_mid_word();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/nibble_demux_assembler.md
Name: nibble_demux_assembler

Overview:
- Receive end of a time-multiplexed 2:1 bus: a mux stage drives the low half (sel=0) and then the high half (sel=1) of a word onto one WIDTH-bit bus.
- This block captures the beats, reassembles them into a 2*WIDTH-bit word and presents it through a valid/ready handshake.
- Sits between the shared narrow bus and wide consumers (register file, ALU operand latches).
- Also flags out-of-order beats and counts delivered words.

Parameters:
WIDTH, 4, width of one bus beat; output word is 2*WIDTH.
TIMEOUT, 15, idle cycles allowed in HALF before a partial word is dropped (used only with DEMUX_TIMEOUT_EN); range 1..255.

Ports:
clk  input  1  single clock, all state updates on rising edge.
reset  input  1  synchronous, active-high; sampled on rising clk.
in_valid  input  1  bus beat present this cycle.
in_sel  input  1  0 = low half beat, 1 = high half beat.
in_data  input  WIDTH  beat payload.
in_ready  output  1  beat accepted this cycle when in_valid & in_ready.
flush  input  1  synchronous drop of any partial or held word.
out_data  output  2*WIDTH  assembled word {high, low}.
out_valid  output  1  out_data holds a complete word.
out_ready  input  1  consumer takes word when out_valid & out_ready.
seq_err  output  1  sticky sequence-error flag.
err_clr  input  1  clears seq_err.
pair_count  output  8  number of completed handoffs, modulo 256.
timeout  output  1  one-cycle pulse when a partial word is dropped by timeout.

Behaviour:
- Reset: state EMPTY, out_data=0, out_valid=0, seq_err=0, pair_count=0, timeout=0, low-half register=0, timeout counter=0.
- in_ready is combinational: 1 when state != FULL, or when state = FULL and out_ready=1.
- States:
  - EMPTY
  - HALF (low half captured)
  - FULL (out_valid=1)
- EMPTY:
  - beat with sel=0: capture low -> HALF.
  - beat with sel=1: discard, set seq_err, stay EMPTY.
- HALF:
  - beat with sel=1: out_data <= {in_data, low} -> FULL. out_valid is 1 in the cycle after the high beat (latency 1).
  - beat with sel=0: overwrite low, set seq_err, stay HALF.
- FULL:
  - out_data and out_valid are held stable until out_ready=1.
  - On handoff, pair_count increments; it wraps 255 -> 0.
  - Handoff with no beat: -> EMPTY, out_valid=0 next cycle.
  - Handoff with a sel=0 beat: capture low -> HALF.
  - Handoff with a sel=1 beat: discard, set seq_err -> EMPTY.
  - A beat arriving while out_ready=0 is not accepted (in_ready=0) and has no effect.
- out_data keeps its last value after handoff; it is only meaningful while out_valid=1.
- flush has priority over beats and handoff:
  - next state EMPTY, out_valid=0.
  - No count increment, no seq_err change.
  - In-cycle beat and handoff are ignored. in_ready still follows its equation, but the beat is dropped.
- seq_err: set has priority over err_clr in the same cycle; err_clr alone clears it next cycle.
- reset has priority over flush and everything else, including mid-word; a partial low half is lost.

Optional Feature:
Macro DEMUX_TIMEOUT_EN.
- Defined:
  - An 8-bit idle counter runs in HALF. It clears on entering HALF and on any accepted beat, and increments every HALF cycle with no beat.
  - When the counter reaches TIMEOUT, the next state is EMPTY and the low half is discarded.
  - timeout pulses 1 for exactly one cycle, the cycle after the drop.
  - seq_err is set.
  - flush or reset clears the counter.
- Not defined: HALF is held indefinitely and timeout is tied to 0. The port list is identical in both builds.

Test Plan:
- Reset, then beats (sel0, 0x5), (sel1, 0xA) with out_ready=1 -> next cycle out_valid=1, out_data=0xA5; pair_count 0 -> 1; following cycle out_valid=0.
- out_ready=0 after the pair 0x3/0xC -> out_valid stays 1 and out_data=0xC3 stable for 5 cycles, in_ready=0, an offered beat is ignored; raise out_ready together with beat (sel0, 0x7) -> handoff, state HALF holding 0x7.
- Beat sel1 in EMPTY -> seq_err=1, no out_valid. err_clr together with another bad beat -> seq_err stays 1. err_clr alone -> seq_err=0.
- Low 0x1 then flush in the same cycle as high 0xF -> no out_valid; the next pair 0x2/0x4 produces 0x42.
- 256 back-to-back words -> pair_count wraps to 0; reset asserted while in HALF -> all outputs at reset values next cycle.
- With DEMUX_TIMEOUT_EN, TIMEOUT=3: low beat then 3 idle cycles -> timeout=1 for one cycle, seq_err=1, a high beat afterwards is a sequence error. Without the macro: same stimulus, timeout stays 0 and a late high beat completes the word.
